// File: rtl/pc_pkg.sv
// Shared definitions for the PC sequencer: FSM state encoding and PC step constants.
package pc_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_EXEC   = 3'd3,
    ST_HALTED = 3'd4
  } state_t;

  localparam logic [63:0] PC_INC   = 64'd4;
  localparam int          BR_SHIFT = 2;

  function automatic logic take_branch(input logic branch, input logic uncond, input logic zero);
    return uncond | (branch & zero);
  endfunction

endpackage

// File: rtl/next_pc_calc.sv
// Combinational next-PC: sequential step or word-offset branch target, modulo 2^64.
module next_pc_calc
  import pc_pkg::*;
(
  input  logic               [63:0] pc,
  input  logic signed        [63:0] imm,
  input  logic                      branch,
  input  logic                      uncond,
  input  logic                      zero,
  output logic               [63:0] next_pc
);

  logic signed [63:0] offset;

  always_comb begin
    offset  = imm <<< BR_SHIFT;
    next_pc = take_branch(branch, uncond, zero) ? (pc + $unsigned(offset)) : (pc + PC_INC);
  end

endmodule

// File: rtl/pc_sequencer.sv
// Instruction sequencer: fetch/decode/exec handshake FSM with ack timeout and retired-instruction count.
module pc_sequencer
  import pc_pkg::*;
#(
  parameter logic [63:0] RESET_VECTOR = 64'h0,
  parameter int unsigned ACK_TIMEOUT  = 16
) (
  input  logic        CLK,
  input  logic        Resetb,
  output logic        IMemReq,
  output logic [63:0] IMemAddr,
  input  logic        IMemAck,
  input  logic [31:0] IMemData,
  output logic [31:0] Instr,
  output logic        InstrValid,
  input  logic        InstrAccept,
  input  logic        ResolveValid,
  input  logic        Branch,
  input  logic        Uncondbranch,
  input  logic        ALUZero,
  input  logic [63:0] SignExtImm64,
  input  logic        Halt,
  output logic [63:0] CurrentPC,
  output logic [31:0] RetiredCount,
  output logic        FetchErr
);

  localparam int TW = $clog2(ACK_TIMEOUT + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(ACK_TIMEOUT - 1);

  state_t        state;
  logic [TW-1:0] tmo_cnt;
  logic [63:0]   next_pc;

  next_pc_calc u_next_pc (
    .pc      (CurrentPC),
    .imm     (SignExtImm64),
    .branch  (Branch),
    .uncond  (Uncondbranch),
    .zero    (ALUZero),
    .next_pc (next_pc)
  );

  always_ff @(posedge CLK or negedge Resetb) begin
    if (!Resetb) begin
      state        <= ST_IDLE;
      CurrentPC    <= RESET_VECTOR;
      Instr        <= 32'd0;
      RetiredCount <= 32'd0;
      FetchErr     <= 1'b0;
      tmo_cnt      <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          state   <= ST_FETCH;
          tmo_cnt <= '0;
        end
        ST_FETCH: begin
          if (IMemAck) begin
            Instr   <= IMemData;
            state   <= ST_DECODE;
            tmo_cnt <= '0;
          end else if (tmo_cnt == TMO_LAST) begin
            FetchErr <= 1'b1;
            state    <= ST_HALTED;
          end else begin
            tmo_cnt <= tmo_cnt + TW'(1);
          end
        end
        ST_DECODE: begin
          if (InstrAccept) state <= ST_EXEC;
        end
        ST_EXEC: begin
          // Halt still retires the resolving instruction before stopping.
          if (ResolveValid) begin
            CurrentPC    <= next_pc;
            RetiredCount <= RetiredCount + 32'd1;
            state        <= Halt ? ST_HALTED : ST_FETCH;
          end
        end
        default: state <= ST_HALTED;
      endcase
    end
  end

  assign IMemReq    = (state == ST_FETCH);
  assign InstrValid = (state == ST_DECODE);
  assign IMemAddr   = CurrentPC;

endmodule

// File: doc/pc_sequencer.md
PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 Parameter: RESET_VECTOR, 64'h0, PC value loaded on reset.
REQ-002 Parameter: ACK_TIMEOUT, 16, max cycles FETCH waits for IMemAck before raising FetchErr.
REQ-003 CLK  input  1  single clock; all state updates on rising edge.
REQ-004 Resetb  input  1  reset, asynchronous, active-low.
REQ-005 IMemReq  output  1  instruction-fetch request to instruction memory.
REQ-006 IMemAddr  output  64  fetch address; equals CurrentPC.
REQ-007 IMemAck  input  1  memory returns IMemData this cycle.
REQ-008 IMemData  input  32  fetched instruction word.
REQ-009 Instr  output  32  registered instruction to decode.
REQ-010 InstrValid  output  1  Instr is valid and awaiting acceptance.
REQ-011 InstrAccept  input  1  decode consumes Instr.
REQ-012 ResolveValid  input  1  branch outcome for the accepted instruction is present.
REQ-013 Branch, Uncondbranch, ALUZero  input  1 each  branch control and zero flag.
REQ-014 SignExtImm64  input  64  sign-extended word offset.
REQ-015 Halt  input  1  sampled with ResolveValid; stops sequencing.
REQ-016 CurrentPC  output  64  architectural PC.
REQ-017 RetiredCount  output  32  count of resolved instructions.
REQ-018 FetchErr  output  1  sticky fetch-timeout flag.

Function
REQ-019 States SHALL be IDLE, FETCH, DECODE, EXEC and HALTED.
REQ-020 IDLE SHALL last exactly one cycle after reset release, then go to FETCH.
REQ-021 FETCH SHALL assert IMemReq, hold IMemAddr stable, and on IMemAck capture IMemData into Instr and go to DECODE.
REQ-022 IMemAck in the first FETCH cycle SHALL be accepted (zero-wait memory); IMemAck outside FETCH SHALL be ignored.
REQ-023 A timeout counter SHALL count FETCH cycles without ack. Reaching ACK_TIMEOUT SHALL set FetchErr and go to HALTED.
REQ-024 DECODE SHALL assert InstrValid with Instr stable until InstrAccept, then go to EXEC. InstrValid SHALL be low in all other states.
REQ-025 EXEC SHALL wait for ResolveValid.
REQ-026 On ResolveValid, NextPC SHALL be CurrentPC + (SignExtImm64 << 2) if Uncondbranch or (Branch and ALUZero), else CurrentPC + 4. The sum SHALL be modulo 2^64, with a silent wrap.
REQ-027 On ResolveValid, CurrentPC SHALL update to NextPC and RetiredCount SHALL increment. RetiredCount SHALL wrap at 2^32.
REQ-028 On ResolveValid, the next state SHALL be HALTED if Halt is high, else FETCH.
REQ-029 Halt SHALL still update CurrentPC and RetiredCount.
REQ-030 Latency: minimum 3 cycles per instruction (FETCH with ack, DECODE with accept, EXEC with resolve).
REQ-031 HALTED SHALL be terminal until reset and SHALL drive IMemReq=0 and InstrValid=0.
REQ-032 Branch inputs outside EXEC SHALL have no effect.

Reset
REQ-033 Async assertion of Resetb SHALL immediately force: state IDLE, CurrentPC=RESET_VECTOR, Instr=0, InstrValid=0, IMemReq=0, RetiredCount=0, FetchErr=0, timeout counter=0.
REQ-034 Reset mid-FETCH SHALL abandon the request; a later ack SHALL be ignored.

Structure
REQ-035 The state enum, PC_INC=4 and the branch-shift amount 2 SHALL live in shared package pc_pkg.
REQ-036 Next-PC arithmetic SHALL be a combinational sub-module next_pc_calc, instantiated once.

Verification
REQ-037 Reset with RESET_VECTOR=64'h1000, zero-wait ack, no branches -> IMemAddr sequence 0x1000, 0x1004, 0x1008; RetiredCount=3 after three resolves.
REQ-038 PC=0x2000, Branch=1, ALUZero=1, SignExtImm64=-2 -> next IMemAddr 0x1FF8. Branch=1, ALUZero=0 -> 0x2004.
REQ-039 Uncondbranch=1, PC=64'hFFFF_FFFF_FFFF_FFFC, Imm=1 -> PC wraps to 0x0.
REQ-040 Ack withheld 16 cycles -> FetchErr=1, HALTED, IMemReq=0. Late ack has no effect.
REQ-041 InstrAccept delayed 5 cycles -> Instr/InstrValid held stable; no second fetch issued.
REQ-042 Resetb low mid-DECODE, then ResolveValid/Halt pulses -> outputs at reset values; resumes fetch at RESET_VECTOR after IDLE.
